// File: rtl/rf_scan_reader_pkg.sv
// Shared types and sizing for the register-file scan reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_scan_reader_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int RF_DEPTH   = 2 ** ADDR_W_DEF;

    // Scan sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rf_scan_reader.sv
// Walks an RF address range on one combinational read port and streams each word out.
// Latency: word captured at the edge ending its READ cycle; one word per 2 cycles with out_ready high.
// Backpressure: holds one word in SEND until out_ready; no new RF read is issued while stalled.
module rf_scan_reader
    import rf_scan_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_cur;
    logic [ADDR_W-1:0]   r_end;
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_valid;
    logic                r_last;
    logic                w_handshake;

    assign w_handshake = r_valid & out_ready;

    // State register; async reset forces IDLE immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; abort overrides everything, including a pending handshake
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: if (start) w_next_state = ST_READ;
                ST_READ: w_next_state = ST_SEND;
                ST_SEND: if (w_handshake) w_next_state = r_last ? ST_DONE : ST_READ;
                ST_DONE: w_next_state = ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Address counter and output word register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur   <= '0;
            r_end   <= '0;
            r_data  <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (abort) begin
            // A word still waiting in SEND is discarded
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cur <= first_addr;
                        r_end <= last_addr;
                    end
                end
                ST_READ: begin
                    // RF read port is combinational: the word for r_cur is valid now
                    r_data  <= rf_rdata;
                    r_addr  <= r_cur;
                    r_last  <= (r_cur == r_end);
                    r_valid <= 1'b1;
                end
                ST_SEND: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        // Natural overflow gives the wrap from the top address back to 0
                        if (!r_last) r_cur <= r_cur + 1'b1;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // The read address only moves when r_cur moves, so it is quiet outside READ
    assign rf_raddr  = r_cur;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_addr  = r_addr;
    assign out_last  = r_last;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_rf_scan_reader.sv
module tb_rf_scan_reader;
    import rf_scan_reader_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [0:RF_DEPTH-1];
    assign rf_rdata = rf[rf_raddr];

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    rf_scan_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int a, input logic l);
        exp_t e;
        e.addr = a[AW-1:0];
        e.data = rf[a];
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic push_range(input int f, input int l);
        int a;
        a = f;
        forever begin
            push(a, a == l);
            if (a == l) break;
            a = (a + 1) % RF_DEPTH;
        end
    endtask

    // Monitor: every accepted word is compared with the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=addr %0d data %0h required=no word", out_addr, out_data);
            end else begin
                mon_e = sb.pop_front();
                check("word{addr,data,last}", {out_addr, out_data, out_last},
                      {mon_e.addr, mon_e.data, mon_e.last});
            end
        end
        if (!rst && done) done_cnt++;
    end

    // Issue one scan and wait for done; optional stall on one word and start-while-busy poke
    task automatic run_scan(input int f, input int l, input int exp_done,
                            input bit poke_busy, input int stall_addr, input int stall_n);
        int dc0;
        int stall_cnt;
        bit stalled;
        bit seen;
        push_range(f, l);
        stall_cnt = 0;
        stalled = 1'b0;
        seen = 1'b0;
        @(posedge clk); #1;
        first_addr = f[AW-1:0];
        last_addr  = l[AW-1:0];
        start = 1'b1;
        dc0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (poke_busy && c == 1) begin
                start = 1'b1;
                first_addr = 5'd20;
                last_addr  = 5'd25;
            end
            if (poke_busy && c == 2) start = 1'b0;
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) out_ready = 1'b1;
            end else if (!stalled && stall_n > 0 && out_valid && out_addr == stall_addr[AW-1:0]) begin
                out_ready = 1'b0;
                stall_cnt = stall_n;
                stalled = 1'b1;
            end
            @(negedge clk);
            if (!out_ready)
                check("stall_hold{valid,addr,data,raddr}", {out_valid, out_addr, out_data, rf_raddr},
                      {1'b1, stall_addr[AW-1:0], rf[stall_addr], stall_addr[AW-1:0]});
            if (done) begin
                check("done_cycle", c, exp_done);
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no done required=done in cycle %0d", exp_done);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("done_pulse_count", done_cnt - dc0, 1);
        check("idle_after_done{busy,done}", {busy, done}, 2'b00);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        int found;
        int dc0;
        for (int i = 0; i < RF_DEPTH; i++) rf[i] = i;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset{valid,last,busy,done}", {out_valid, out_last, busy, done}, 4'b0000);
        check("reset_rf_raddr", rf_raddr, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_addr", out_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full range, including address 0
        run_scan(0, 31, 65, 1'b0, 0, 0);
        // Wrap-around 30,31,0,1
        run_scan(30, 1, 9, 1'b0, 0, 0);
        // Backpressure on word 4 for 5 cycles
        run_scan(2, 6, 16, 1'b0, 4, 5);
        // Single word, start pulsed again while busy
        run_scan(7, 7, 3, 1'b1, 0, 0);

        // Abort while word 10 is waiting in SEND
        push(8, 1'b0);
        push(9, 1'b0);
        @(posedge clk); #1;
        first_addr = 5'd8;
        last_addr  = 5'd15;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid && out_addr == 5'd10) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (found == 0) begin
            checks++;
            errors++;
            $display("FAIL abort_word10_timeout actual=not seen required=word 10 in SEND");
        end
        out_ready = 1'b0;
        abort = 1'b1;
        dc0 = done_cnt;
        @(posedge clk); #1;
        abort = 1'b0;
        check("after_abort{valid,busy,last}", {out_valid, busy, out_last}, 3'b000);
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt - dc0, 0);
        check("abort_scoreboard_empty", sb.size(), 0);
        out_ready = 1'b1;
        run_scan(0, 0, 3, 1'b0, 0, 0);

        // Async reset mid-scan; RF word 5 rewritten before it is read
        push_range(0, 7);
        sb.delete();
        push(0, 1'b0);
        push(1, 1'b0);
        push(2, 1'b0);
        @(posedge clk); #1;
        first_addr = 5'd0;
        last_addr  = 5'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid && out_addr == 5'd3) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (found == 0) begin
            checks++;
            errors++;
            $display("FAIL reset_word3_timeout actual=not seen required=word 3 in SEND");
        end
        rf[5] = 32'hDEADBEEF;
        #1;
        rst = 1'b1;
        #1;
        check("async_reset{valid,last,busy,done}", {out_valid, out_last, busy, done}, 4'b0000);
        check("async_reset_addrs{raddr,out_addr}", {rf_raddr, out_addr}, 10'd0);
        check("async_reset_out_data", out_data, 0);
        check("reset_scoreboard_empty", sb.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rf5_rewritten", rf[5], 32'hDEADBEEF);
        run_scan(4, 6, 7, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
